// File: rtl/fp_cmp_pipe.sv
// Two-stage pipelined IEEE-754 compare/min/max unit (RISC-V FEQ/FLT/FLE/FMIN/FMAX semantics).
// Stage 1 registers operands plus field decode; stage 2 registers the result, tag and NV flag.
module fp_cmp_pipe #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int TAG_WIDTH = 4,
  localparam int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_valid,
  output logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_numA,
  input  logic [DATA_WIDTH-1:0] in_numB,
  input  logic [2:0]            in_cmp_type,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_flag_NV
);

  localparam logic [2:0] OP_LE  = 3'b000;
  localparam logic [2:0] OP_LT  = 3'b001;
  localparam logic [2:0] OP_EQ  = 3'b010;
  localparam logic [2:0] OP_MIN = 3'b011;
  localparam logic [2:0] OP_MAX = 3'b100;

  localparam logic [DATA_WIDTH-1:0] CANON_QNAN =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic sign;
    logic exp_zero;
    logic exp_ones;
    logic man_zero;
    logic nan;
    logic snan;
    logic zero;
  } dec_t;

  function automatic dec_t decode(input logic [DATA_WIDTH-1:0] x);
    dec_t d;
    d.sign     = x[DATA_WIDTH-1];
    d.exp_zero = (x[DATA_WIDTH-2:MAN_WIDTH] == {EXP_WIDTH{1'b0}});
    d.exp_ones = &x[DATA_WIDTH-2:MAN_WIDTH];
    d.man_zero = (x[MAN_WIDTH-1:0] == {MAN_WIDTH{1'b0}});
    d.nan      = d.exp_ones & ~d.man_zero;
    d.snan     = d.nan & ~x[MAN_WIDTH-1];
    d.zero     = d.exp_zero & d.man_zero;
    return d;
  endfunction

  logic                  rdy_en_r;
  logic                  s1_valid_r;
  logic [DATA_WIDTH-1:0] s1_a_r;
  logic [DATA_WIDTH-1:0] s1_b_r;
  logic [2:0]            s1_op_r;
  logic [TAG_WIDTH-1:0]  s1_tag_r;
  dec_t                  s1_a_dec_r;
  dec_t                  s1_b_dec_r;

  logic                  s2_valid_r;
  logic [DATA_WIDTH-1:0] s2_data_r;
  logic [TAG_WIDTH-1:0]  s2_tag_r;
  logic                  s2_nv_r;

  logic                  s1_load_s;
  logic                  s2_load_s;
  logic [DATA_WIDTH-1:0] res_s;
  logic                  nv_s;
  logic                  eq_s;
  logic                  a_lt_s;
  logic                  b_lt_s;
  logic                  any_nan_s;
  logic                  any_snan_s;
  logic                  both_zero_s;
  logic                  unused_dec_s;

  // A stage loads when it is empty or its contents move on this cycle.
  assign s2_load_s = ~s2_valid_r | in_ready;
  assign s1_load_s = rdy_en_r & (~s1_valid_r | s2_load_s);
  assign out_ready = s1_load_s;

  assign out_valid   = s2_valid_r;
  assign out_data    = s2_data_r;
  assign out_tag     = s2_tag_r;
  assign out_flag_NV = s2_nv_r;

  assign unused_dec_s = ^{s1_a_dec_r.exp_zero, s1_a_dec_r.exp_ones, s1_a_dec_r.man_zero,
                          s1_b_dec_r.exp_zero, s1_b_dec_r.exp_ones, s1_b_dec_r.man_zero};

  // Request acceptance is held off until the first clock after reset release.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rdy_en_r <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
    end
  end

  // Stage 1: operand, op, tag and decode capture.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {DATA_WIDTH{1'b0}};
      s1_b_r     <= {DATA_WIDTH{1'b0}};
      s1_op_r    <= 3'b000;
      s1_tag_r   <= {TAG_WIDTH{1'b0}};
      s1_a_dec_r <= '0;
      s1_b_dec_r <= '0;
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_a_r     <= in_numA;
        s1_b_r     <= in_numB;
        s1_op_r    <= in_cmp_type;
        s1_tag_r   <= in_tag;
        s1_a_dec_r <= decode(in_numA);
        s1_b_dec_r <= decode(in_numB);
      end
    end
  end

  // Ordering relation between the stage-1 operands (NaNs handled by the caller).
  always_comb begin
    any_nan_s   = s1_a_dec_r.nan | s1_b_dec_r.nan;
    any_snan_s  = s1_a_dec_r.snan | s1_b_dec_r.snan;
    both_zero_s = s1_a_dec_r.zero & s1_b_dec_r.zero;
    eq_s        = both_zero_s | (s1_a_r == s1_b_r);
    if (both_zero_s) begin
      a_lt_s = 1'b0;
    end else if (s1_a_dec_r.sign != s1_b_dec_r.sign) begin
      a_lt_s = s1_a_dec_r.sign;
    end else if (s1_a_dec_r.sign) begin
      a_lt_s = s1_a_r[DATA_WIDTH-2:0] > s1_b_r[DATA_WIDTH-2:0];
    end else begin
      a_lt_s = s1_a_r[DATA_WIDTH-2:0] < s1_b_r[DATA_WIDTH-2:0];
    end
    b_lt_s = ~a_lt_s & ~eq_s;
  end

  // Result and invalid flag per operation.
  always_comb begin
    res_s = {DATA_WIDTH{1'b0}};
    nv_s  = 1'b0;
    case (s1_op_r)
      OP_LE: begin
        res_s = {{(DATA_WIDTH-1){1'b0}}, ~any_nan_s & (a_lt_s | eq_s)};
        nv_s  = any_nan_s;
      end
      OP_LT: begin
        res_s = {{(DATA_WIDTH-1){1'b0}}, ~any_nan_s & a_lt_s};
        nv_s  = any_nan_s;
      end
      OP_EQ: begin
        res_s = {{(DATA_WIDTH-1){1'b0}}, ~any_nan_s & eq_s};
        nv_s  = any_snan_s;
      end
      OP_MIN: begin
        nv_s = any_snan_s;
        if (s1_a_dec_r.nan & s1_b_dec_r.nan) begin
          res_s = CANON_QNAN;
        end else if (s1_a_dec_r.nan) begin
          res_s = s1_b_r;
        end else if (s1_b_dec_r.nan) begin
          res_s = s1_a_r;
        end else if (both_zero_s) begin
          // -0 orders below +0 for min/max only.
          res_s = s1_a_dec_r.sign ? s1_a_r : s1_b_r;
        end else begin
          res_s = b_lt_s ? s1_b_r : s1_a_r;
        end
      end
      OP_MAX: begin
        nv_s = any_snan_s;
        if (s1_a_dec_r.nan & s1_b_dec_r.nan) begin
          res_s = CANON_QNAN;
        end else if (s1_a_dec_r.nan) begin
          res_s = s1_b_r;
        end else if (s1_b_dec_r.nan) begin
          res_s = s1_a_r;
        end else if (both_zero_s) begin
          res_s = s1_a_dec_r.sign ? s1_b_r : s1_a_r;
        end else begin
          res_s = a_lt_s ? s1_b_r : s1_a_r;
        end
      end
      default: begin
        res_s = {DATA_WIDTH{1'b0}};
        nv_s  = 1'b0;
      end
    endcase
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {DATA_WIDTH{1'b0}};
      s2_tag_r   <= {TAG_WIDTH{1'b0}};
      s2_nv_r    <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_data_r <= res_s;
        s2_tag_r  <= s1_tag_r;
        s2_nv_r   <= nv_s;
      end
    end
  end

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Randomized bench for fp_cmp_pipe: single-precision and double-precision builds
// checked against a signed-key reference model, plus directed zero/NaN/stall cases.
module tb_fp_cmp_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        v32, ordy32, irdy32, ov32, nv32;
  logic [31:0] a32, b32, d32;
  logic [2:0]  op32;
  logic [3:0]  t32, ot32;

  logic        v64, ordy64, irdy64, ov64, nv64;
  logic [63:0] a64, b64, d64;
  logic [2:0]  op64;
  logic [3:0]  t64, ot64;

  fp_cmp_pipe dut32 (
    .in_clk(clk), .in_rst_n(rst_n), .in_valid(v32), .out_ready(ordy32),
    .in_numA(a32), .in_numB(b32), .in_cmp_type(op32), .in_tag(t32),
    .out_valid(ov32), .in_ready(irdy32), .out_data(d32), .out_tag(ot32),
    .out_flag_NV(nv32)
  );

  fp_cmp_pipe #(.EXP_WIDTH(11), .MAN_WIDTH(52)) dut64 (
    .in_clk(clk), .in_rst_n(rst_n), .in_valid(v64), .out_ready(ordy64),
    .in_numA(a64), .in_numB(b64), .in_cmp_type(op64), .in_tag(t64),
    .out_valid(ov64), .in_ready(irdy64), .out_data(d64), .out_tag(ot64),
    .out_flag_NV(nv64)
  );

  typedef struct { logic [63:0] a; logic [63:0] b; logic [2:0] op; } req_t;
  typedef struct { logic [64:0] r; logic [3:0] tag; int cyc; } exp_t;

  req_t req_q[$];
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sel = 0;
  int vmode = 1;
  int rmode = 1;
  bit lat_chk = 1'b0;
  int ordy_low = 0;
  logic [3:0] tag_cnt = 4'd0;
  bit hold_pend = 1'b0;
  logic [69:0] hold_val;

  // Reference: map each non-NaN value to a signed integer key (both zeros map to 0).
  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [2:0] op, input int ew, input int mw);
    logic [63:0] mmask, manmask, emax, ma, mb, canon;
    logic sa, sb, nan_a, nan_b, snan_a, snan_b, anynan, anysnan;
    longint ka, kb;
    mmask   = (64'd1 << (ew + mw)) - 64'd1;
    manmask = (64'd1 << mw) - 64'd1;
    emax    = (64'd1 << ew) - 64'd1;
    ma = a & mmask;
    mb = b & mmask;
    sa = a[ew+mw];
    sb = b[ew+mw];
    nan_a  = ((ma >> mw) == emax) && ((a & manmask) != 64'd0);
    nan_b  = ((mb >> mw) == emax) && ((b & manmask) != 64'd0);
    snan_a = nan_a && !a[mw-1];
    snan_b = nan_b && !b[mw-1];
    anynan  = nan_a || nan_b;
    anysnan = snan_a || snan_b;
    ka = longint'(ma);
    kb = longint'(mb);
    if (sa) ka = -ka;
    if (sb) kb = -kb;
    canon = (emax << mw) | (64'd1 << (mw - 1));
    case (op)
      3'd0: return {anynan, 63'd0, (!anynan && ka <= kb)};
      3'd1: return {anynan, 63'd0, (!anynan && ka < kb)};
      3'd2: return {anysnan, 63'd0, (!anynan && ka == kb)};
      3'd3, 3'd4: begin
        if (nan_a && nan_b) return {anysnan, canon};
        if (nan_a) return {anysnan, b};
        if (nan_b) return {anysnan, a};
        if (ka == kb) begin
          if (ma == 64'd0 && mb == 64'd0)
            return {1'b0, ((op == 3'd3) == sa) ? a : b};
          return {1'b0, a};
        end
        if (op == 3'd3) return {1'b0, (ka < kb) ? a : b};
        return {1'b0, (ka > kb) ? a : b};
      end
      default: return 65'd0;
    endcase
  endfunction

  function automatic logic [63:0] gen(input int ew, input int mw);
    logic [63:0] s, e, m, emax;
    emax = (64'd1 << ew) - 64'd1;
    s = 64'($urandom_range(1));
    case ($urandom_range(3))
      0: e = 64'd0;
      1: e = emax;
      default: e = {$urandom, $urandom} & emax;
    endcase
    case ($urandom_range(3))
      0: m = 64'd0;
      1: m = 64'd1 << (mw - 1);
      2: m = 64'd1;
      default: m = {$urandom, $urandom} & ((64'd1 << mw) - 64'd1);
    endcase
    return (s << (ew + mw)) | (e << mw) | m;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_rand(input int n);
    int ew, mw;
    req_t r;
    ew = (sel == 0) ? 8 : 11;
    mw = (sel == 0) ? 23 : 52;
    for (int i = 0; i < n; i++) begin
      r.a = gen(ew, mw);
      case ($urandom_range(7))
        0, 1: r.b = r.a;
        2: r.b = r.a ^ (64'd1 << (ew + mw));
        default: r.b = gen(ew, mw);
      endcase
      r.op = ($urandom_range(9) == 0) ? 3'(5 + $urandom_range(2)) : 3'($urandom_range(4));
      req_q.push_back(r);
    end
  endtask

  task automatic push_req(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
    req_t r;
    r.a = a; r.b = b; r.op = op;
    req_q.push_back(r);
  endtask

  // One cycle: drive at negedge, sample after settling, compare and score.
  task automatic step();
    bit pv, pr, o_v, o_rdy, o_nv;
    logic [63:0] o_d;
    logic [3:0] o_t;
    exp_t e;
    req_t r;
    @(negedge clk);
    pv = (req_q.size() > 0) && ((vmode != 0) || ($urandom_range(3) != 0));
    case (rmode)
      0: pr = ($urandom_range(1) == 1);
      2: pr = ((cyc % 3) == 0);
      default: pr = 1'b1;
    endcase
    v32 = 1'b0; v64 = 1'b0; irdy32 = 1'b1; irdy64 = 1'b1;
    if (sel == 0) begin
      v32 = pv; irdy32 = pr; t32 = tag_cnt;
      if (pv) begin a32 = req_q[0].a[31:0]; b32 = req_q[0].b[31:0]; op32 = req_q[0].op; end
    end else begin
      v64 = pv; irdy64 = pr; t64 = tag_cnt;
      if (pv) begin a64 = req_q[0].a; b64 = req_q[0].b; op64 = req_q[0].op; end
    end
    #1;
    o_v   = (sel == 0) ? ov32 : ov64;
    o_rdy = (sel == 0) ? ordy32 : ordy64;
    o_d   = (sel == 0) ? {32'd0, d32} : d64;
    o_t   = (sel == 0) ? ot32 : ot64;
    o_nv  = (sel == 0) ? nv32 : nv64;
    if (hold_pend) chk("stall_hold", {o_v, o_nv, o_t, o_d}, hold_val);
    hold_pend = o_v && !pr;
    hold_val  = {o_v, o_nv, o_t, o_d};
    if (o_v && pr) begin
      if (exp_q.size() == 0) begin
        chk("spurious_result", 128'd1, 128'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", {o_nv, o_d}, e.r);
        chk("tag", o_t, e.tag);
        if (lat_chk) chk("latency", cyc - e.cyc, 2);
      end
    end
    if (pv && lat_chk && !o_rdy) ordy_low++;
    if (pv && o_rdy) begin
      r = req_q.pop_front();
      e.r = (sel == 0) ? model(r.a, r.b, r.op, 8, 23) : model(r.a, r.b, r.op, 11, 52);
      e.tag = tag_cnt;
      e.cyc = cyc;
      exp_q.push_back(e);
      tag_cnt++;
    end
    cyc++;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4000 && (req_q.size() > 0 || exp_q.size() > 0); i++) step();
    chk(name, req_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    v32 = 1'b1; a32 = 32'h3F800000; b32 = 32'h40000000; op32 = 3'd1; t32 = 4'd5; irdy32 = 1'b1;
    v64 = 1'b1; a64 = 64'd0; b64 = 64'd0; op64 = 3'd0; t64 = 4'd7; irdy64 = 1'b1;

    // Pin the reference model with hand-computed values.
    chk("m_lt_1_2",    model(64'h3F800000, 64'h40000000, 3'd1, 8, 23), 65'd1);
    chk("m_eq_zeros",  model(64'h80000000, 64'h00000000, 3'd2, 8, 23), 65'd1);
    chk("m_lt_sign",   model(64'hBF800000, 64'h3F800000, 3'd1, 8, 23), 65'd1);
    chk("m_lt_neg",    model(64'hC0000000, 64'hBF800000, 3'd1, 8, 23), 65'd1);
    chk("m_min_zero",  model(64'h00000000, 64'h80000000, 3'd3, 8, 23), 65'h0_80000000);
    chk("m_eq_qnan",   model(64'h7FC00000, 64'h3F800000, 3'd2, 8, 23), 65'd0);
    chk("m_eq_snan",   model(64'h7F800001, 64'h3F800000, 3'd2, 8, 23), {1'b1, 64'd0});
    chk("m_le_qnan",   model(64'h7FC00000, 64'h3F800000, 3'd0, 8, 23), {1'b1, 64'd0});
    chk("m_max_qnan",  model(64'h7FC00000, 64'h40000000, 3'd4, 8, 23), 65'h0_40000000);
    chk("m_min_2nan",  model(64'h7FC00000, 64'h7F800001, 3'd3, 8, 23), {1'b1, 64'h7FC00000});
    chk("m_lt_dp",     model(64'h3FF0000000000000, 64'h4000000000000000, 3'd1, 11, 52), 65'd1);
    chk("m_max_dp",    model(64'hFFF0000000000000, 64'h7FF8000000000000, 3'd4, 11, 52),
        {1'b0, 64'hFFF0000000000000});

    // Reset held with a request pending: outputs must stay cleared.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out32", {ov32, d32, ot32, nv32}, 0);
    chk("rst_out64", {ov64, d64, ot64, nv64}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single-precision cases, unstalled so latency is exact.
    sel = 0; vmode = 1; rmode = 1; lat_chk = 1'b1;
    push_req(64'h3F800000, 64'h40000000, 3'd1);
    push_req(64'h80000000, 64'h00000000, 3'd2);
    push_req(64'hBF800000, 64'h3F800000, 3'd1);
    push_req(64'hC0000000, 64'hBF800000, 3'd1);
    push_req(64'h00000000, 64'h80000000, 3'd3);
    push_req(64'h00000000, 64'h80000000, 3'd4);
    push_req(64'h7FC00000, 64'h3F800000, 3'd2);
    push_req(64'h7F800001, 64'h3F800000, 3'd2);
    push_req(64'h7FC00000, 64'h3F800000, 3'd0);
    push_req(64'h7FC00000, 64'h40000000, 3'd4);
    push_req(64'h7FC00000, 64'h7F800001, 3'd3);
    push_req(64'h3F800000, 64'h40000000, 3'd6);
    drain("drain_directed");

    // Backpressure: 8 back-to-back ops with in_ready 1,0,0,1,...
    lat_chk = 1'b0; rmode = 2;
    push_rand(8);
    drain("drain_backpressure");

    // Throughput: 16 ops, consumer always ready.
    rmode = 1; lat_chk = 1'b1; ordy_low = 0;
    push_rand(16);
    drain("drain_throughput");
    chk("ready_stays_high", ordy_low, 0);

    // Reset in the middle of a stream discards in-flight work.
    lat_chk = 1'b0;
    push_rand(4);
    step(); step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ov", ov32, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req_q.delete(); exp_q.delete(); hold_pend = 1'b0;
    repeat (4) step();
    chk("midrst_flush", ov32, 1'b0);

    // Random single precision.
    vmode = 0; rmode = 0;
    push_rand(400);
    drain("drain_rand32");

    // Double precision: directed then random.
    sel = 1; vmode = 1; rmode = 1; lat_chk = 1'b1;
    push_req(64'h3FF0000000000000, 64'h4000000000000000, 3'd1);
    push_req(64'hFFF0000000000000, 64'h7FF8000000000000, 3'd4);
    push_req(64'h8000000000000000, 64'h0000000000000000, 3'd3);
    push_req(64'h7FF0000000000001, 64'h3FF0000000000000, 3'd2);
    drain("drain_directed64");
    lat_chk = 1'b0; vmode = 0; rmode = 0;
    push_rand(400);
    drain("drain_rand64");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
